// File: rtl/timer_pkg.sv
// Shared constants for the timeout timer: FSM state encoding, mode values
// and default widths.
package timer_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int PRE_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/timeout_timer_if.sv
// Control/status bundle between a protocol FSM (master) and the timeout
// timer (slave).
interface timeout_timer_if
  import timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int PRE_W = PRE_W_DEF
);
  logic             cnt_en;
  logic             cnt_pulse;
  logic             restart;
  logic             mode;
  logic [CNT_W-1:0] limit;
  logic [PRE_W-1:0] prescale;
  logic             timeout;
  logic             expired;
  logic             busy;
  logic [CNT_W-1:0] count;

  modport master (
    output cnt_en, cnt_pulse, restart, mode, limit, prescale,
    input  timeout, expired, busy, count
  );

  modport slave (
    input  cnt_en, cnt_pulse, restart, mode, limit, prescale,
    output timeout, expired, busy, count
  );
endinterface

// File: rtl/timer_prescaler.sv
// Pulse divider: tick_out strobes combinationally on every (div+1)-th
// pulse_in; clr returns the divider to its first pulse.
module timer_prescaler #(
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             pulse_in,
  input  logic [PRE_W-1:0] div,
  output logic             tick_out
);
  logic [PRE_W-1:0] cnt_q, cnt_d;

  assign tick_out = pulse_in && (cnt_q == div);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (pulse_in)
      cnt_d = tick_out ? '0 : cnt_q + PRE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end
endmodule

// File: rtl/timeout_timer.sv
// Programmable tick-counting timeout timer with one-shot/periodic modes.
// Define TIMER_PRESCALE_EN to divide cnt_pulse by (prescale + 1).
module timeout_timer
  import timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int PRE_W = PRE_W_DEF
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  timeout_timer_if.slave tif
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic             mode_q, mode_d;
  logic             expired_q, expired_d;
  logic             timeout_q, timeout_d;
  logic             tick;
  logic [CNT_W-1:0] cnt_inc;
  logic             terminal;

  // A limit of zero would never match an incremented count; treat it as one.
  function automatic logic [CNT_W-1:0] clamp_limit(input logic [CNT_W-1:0] l);
    return (l == '0) ? CNT_W'(1) : l;
  endfunction

`ifdef TIMER_PRESCALE_EN
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             pre_clr;

  assign pre_clr = !tif.cnt_en || tif.restart || (state_q != ST_RUN);
  assign pre_d   = (state_q == ST_IDLE || tif.restart) ? tif.prescale : pre_q;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n)
      pre_q <= '0;
    else if (tif.cnt_en)
      pre_q <= pre_d;
  end

  timer_prescaler #(.PRE_W(PRE_W)) u_prescaler (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .clr      (pre_clr),
    .pulse_in (tif.cnt_pulse),
    .div      (pre_q),
    .tick_out (tick)
  );
`else
  logic [PRE_W-1:0] unused_prescale;
  assign unused_prescale = tif.prescale;
  assign tick            = tif.cnt_pulse;
`endif

  // count < limit_q always holds in RUN, so the increment cannot overflow
  assign cnt_inc  = count_q + CNT_W'(1);
  assign terminal = tick && (cnt_inc == limit_q);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!tif.cnt_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_RUN;
        ST_RUN: begin
          if (tif.restart)
            state_d = ST_RUN;
          else if (terminal && mode_q == MODE_ONESHOT)
            state_d = ST_DONE;
        end
        ST_DONE: if (tif.restart) state_d = ST_RUN;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    count_d   = count_q;
    limit_d   = limit_q;
    mode_d    = mode_q;
    expired_d = expired_q;
    timeout_d = 1'b0;
    if (!tif.cnt_en) begin
      count_d   = '0;
      expired_d = 1'b0;
    end else if (state_q == ST_IDLE || tif.restart) begin
      // Entering or re-entering RUN: latch configuration, discard any tick.
      count_d   = '0;
      expired_d = 1'b0;
      limit_d   = clamp_limit(tif.limit);
      mode_d    = tif.mode;
    end else if (state_q == ST_RUN && tick) begin
      if (cnt_inc == limit_q) begin
        timeout_d = 1'b1;
        if (mode_q == MODE_PERIODIC) begin
          count_d = '0;
        end else begin
          count_d   = limit_q;
          expired_d = 1'b1;
        end
      end else begin
        count_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      count_q   <= '0;
      limit_q   <= '0;
      mode_q    <= MODE_ONESHOT;
      expired_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      limit_q   <= limit_d;
      mode_q    <= mode_d;
      expired_q <= expired_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    tif.busy    = (state_q == ST_RUN);
    tif.timeout = timeout_q;
    tif.expired = expired_q;
    tif.count   = count_q;
  end
endmodule

// File: tb/tb_timeout_timer.sv
// Directed testbench for timeout_timer (CNT_W = 4); expected values are
// hand-derived from the timer's behaviour.
module tb_timeout_timer;
  localparam int CW = 4;
  localparam int PW = 8;

  logic sys_clk;
  logic sys_rst_n;
  int   errors;
  int   checks;

  timeout_timer_if #(.CNT_W(CW), .PRE_W(PW)) tif ();

  timeout_timer #(.CNT_W(CW), .PRE_W(PW)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .tif       (tif)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Drop enable for one edge, then enable with the given configuration.
  // After return the enable-rise edge has passed (DUT in RUN, count 0).
  task automatic start(input logic [CW-1:0] lim, input logic md,
                       input logic [PW-1:0] pre, input logic pulse);
    tif.cnt_en    = 1'b0;
    tif.restart   = 1'b0;
    tif.cnt_pulse = 1'b0;
    step();
    tif.limit     = lim;
    tif.mode      = md;
    tif.prescale  = pre;
    tif.cnt_en    = 1'b1;
    tif.cnt_pulse = pulse;
    step();
  endtask

  task automatic test_reset();
    sys_rst_n     = 1'b0;
    tif.cnt_en    = 1'b1;
    tif.cnt_pulse = 1'b1;
    tif.restart   = 1'b0;
    tif.mode      = 1'b0;
    tif.limit     = 4'd1;
    tif.prescale  = '0;
    step();
    step();
    checks++; if (tif.count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", tif.count); end
    checks++; if (tif.timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b want=0", tif.timeout); end
    checks++; if (tif.expired !== 1'b0) begin errors++; $display("FAIL reset_expired got=%b want=0", tif.expired); end
    checks++; if (tif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", tif.busy); end
    sys_rst_n  = 1'b1;
    tif.cnt_en = 1'b0;
    step();
  endtask

  task automatic test_oneshot();
    start(4'd5, 1'b0, '0, 1'b1);
    checks++; if (tif.count !== 4'd0 || tif.busy !== 1'b1) begin errors++; $display("FAIL rise_tick count=%0d busy=%b want count=0 busy=1", tif.count, tif.busy); end
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++; if (tif.count !== CW'(k) || tif.timeout !== 1'b0) begin errors++; $display("FAIL oneshot_cnt%0d count=%0d timeout=%b want count=%0d timeout=0", k, tif.count, tif.timeout, k); end
    end
    step();
    checks++; if (tif.timeout !== 1'b1) begin errors++; $display("FAIL oneshot_timeout got=%b want=1", tif.timeout); end
    checks++; if (tif.count !== 4'd5 || tif.expired !== 1'b1 || tif.busy !== 1'b0) begin errors++; $display("FAIL oneshot_done count=%0d expired=%b busy=%b want 5 1 0", tif.count, tif.expired, tif.busy); end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (tif.count !== 4'd5 || tif.timeout !== 1'b0 || tif.expired !== 1'b1) begin errors++; $display("FAIL oneshot_hold count=%0d timeout=%b expired=%b want 5 0 1", tif.count, tif.timeout, tif.expired); end
    end
  endtask

  task automatic test_periodic();
    int nto;
    logic [CW-1:0] exp_cnt;
    nto = 0;
    start(4'd3, 1'b1, '0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tif.cnt_pulse = 1'b1;
      step();
      tif.cnt_pulse = 1'b0;
      exp_cnt = CW'((i + 1) % 3);
      if (tif.timeout === 1'b1) nto++;
      checks++; if (tif.count !== exp_cnt || tif.timeout !== (exp_cnt == 4'd0) || tif.expired !== 1'b0) begin errors++; $display("FAIL periodic_tick%0d count=%0d timeout=%b expired=%b want count=%0d timeout=%b expired=0", i, tif.count, tif.timeout, tif.expired, exp_cnt, exp_cnt == 4'd0); end
      step();
      checks++; if (tif.timeout !== 1'b0 || tif.busy !== 1'b1) begin errors++; $display("FAIL periodic_gap%0d timeout=%b busy=%b want 0 1", i, tif.timeout, tif.busy); end
      step();
      step();
    end
    checks++; if (nto !== 3) begin errors++; $display("FAIL periodic_count got=%0d timeouts want=3", nto); end
  endtask

  task automatic test_limit_zero();
    start(4'd0, 1'b0, '0, 1'b1);
    step();
    checks++; if (tif.timeout !== 1'b1 || tif.count !== 4'd1 || tif.expired !== 1'b1) begin errors++; $display("FAIL limit_zero timeout=%b count=%0d expired=%b want 1 1 1", tif.timeout, tif.count, tif.expired); end
  endtask

  task automatic test_limit_max();
    start(4'd15, 1'b0, '0, 1'b1);
    tif.limit = 4'd2;
    for (int k = 1; k <= 14; k++) begin
      step();
      checks++; if (tif.timeout !== 1'b0 || tif.count !== CW'(k)) begin errors++; $display("FAIL limit_max_cnt%0d count=%0d timeout=%b want count=%0d timeout=0", k, tif.count, tif.timeout, k); end
    end
    step();
    checks++; if (tif.timeout !== 1'b1 || tif.count !== 4'd15) begin errors++; $display("FAIL limit_max_term timeout=%b count=%0d want 1 15", tif.timeout, tif.count); end
    step();
    checks++; if (tif.count !== 4'd15 || tif.timeout !== 1'b0) begin errors++; $display("FAIL limit_max_nowrap count=%0d timeout=%b want 15 0", tif.count, tif.timeout); end
  endtask

  task automatic test_abort();
    start(4'd5, 1'b0, '0, 1'b1);
    step();
    step();
    checks++; if (tif.count !== 4'd2) begin errors++; $display("FAIL abort_pre count=%0d want=2", tif.count); end
    tif.cnt_en = 1'b0;
    step();
    checks++; if (tif.count !== 4'd0 || tif.busy !== 1'b0 || tif.expired !== 1'b0 || tif.timeout !== 1'b0) begin errors++; $display("FAIL abort_idle count=%0d busy=%b expired=%b timeout=%b want 0 0 0 0", tif.count, tif.busy, tif.expired, tif.timeout); end
  endtask

  task automatic test_restart_terminal();
    start(4'd3, 1'b0, '0, 1'b1);
    step();
    step();
    tif.restart = 1'b1;
    tif.limit   = 4'd7;
    step();
    tif.restart = 1'b0;
    checks++; if (tif.timeout !== 1'b0 || tif.count !== 4'd0 || tif.busy !== 1'b1 || tif.expired !== 1'b0) begin errors++; $display("FAIL restart_term timeout=%b count=%0d busy=%b expired=%b want 0 0 1 0", tif.timeout, tif.count, tif.busy, tif.expired); end
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++; if (tif.count !== CW'(k) || tif.timeout !== 1'b0) begin errors++; $display("FAIL restart_cnt%0d count=%0d timeout=%b want count=%0d timeout=0", k, tif.count, tif.timeout, k); end
    end
    step();
    checks++; if (tif.timeout !== 1'b1 || tif.count !== 4'd7 || tif.expired !== 1'b1) begin errors++; $display("FAIL restart_newlim timeout=%b count=%0d expired=%b want 1 7 1", tif.timeout, tif.count, tif.expired); end
  endtask

  task automatic test_reset_midrun();
    start(4'd5, 1'b0, '0, 1'b1);
    repeat (4) step();
    checks++; if (tif.count !== 4'd4) begin errors++; $display("FAIL midrun_pre count=%0d want=4", tif.count); end
    sys_rst_n = 1'b0;
    step();
    checks++; if (tif.count !== 4'd0 || tif.busy !== 1'b0 || tif.expired !== 1'b0 || tif.timeout !== 1'b0) begin errors++; $display("FAIL midrun_reset count=%0d busy=%b expired=%b timeout=%b want 0 0 0 0", tif.count, tif.busy, tif.expired, tif.timeout); end
    sys_rst_n  = 1'b1;
    tif.cnt_en = 1'b0;
    step();
  endtask

  task automatic test_prescale();
    int exp_n;
`ifdef TIMER_PRESCALE_EN
    exp_n = 6;
`else
    exp_n = 2;
`endif
    start(4'd2, 1'b0, 8'd2, 1'b1);
    for (int n = 1; n <= 7; n++) begin
      step();
      checks++; if (tif.timeout !== (n == exp_n)) begin errors++; $display("FAIL prescale_pulse%0d timeout=%b want=%b", n, tif.timeout, n == exp_n); end
    end
    tif.cnt_en    = 1'b0;
    tif.cnt_pulse = 1'b0;
    step();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_oneshot();
    test_periodic();
    test_limit_zero();
    test_limit_max();
    test_abort();
    test_restart_terminal();
    test_reset_midrun();
    test_prescale();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
